// File: rtl/apb_i2c_master.sv
// APB-programmed single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Latency: start write to busy=0 is 80*CLK_DIV clk on the ACK path, 44*CLK_DIV on address NACK.
// Backpressure: none; pready is tied high, START writes while busy are dropped.
//
// Ports:
//   clk, rst                        system clock, async active-high reset
//   psel/penable/pwrite/paddr/pwdata APB slave request; prdata (comb from paddr), pready (=1)
//   scl_oe, sda_oe                  open-drain pulldown enables (1 = pull low)
//   sda_i                           sampled SDA pad level
module apb_i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [2:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, nxt_state;
    logic [7:0] div_cnt;
    logic [1:0] qtr;
    logic [2:0] bit_cnt, nxt_bit;

    logic [7:0] addr_reg, tx_reg, rx_reg;
    logic [7:0] addr_snap, tx_snap, rx_shift;
    logic       nack_flg, done_flg, sda_smp;

    logic apb_wr, start_go, q_last, smp_pt, cell_last, nack_set, done_set, busy;

    assign apb_wr    = psel & penable & pwrite;
    assign busy      = (state != S_IDLE);
    assign start_go  = apb_wr && (paddr == 3'd4) && pwdata[0] && !busy;
    assign q_last    = (div_cnt == DIV_LAST);
    assign smp_pt    = q_last && (qtr == 2'd2);
    assign cell_last = q_last && (qtr == 2'd3);
    // Slave NACK is observed on the address ACK cell, and on the data ACK cell for writes only.
    assign nack_set  = smp_pt && sda_i &&
                       ((state == S_AACK) || ((state == S_DACK) && !addr_snap[0]));
    assign done_set  = cell_last && (state == S_STOP);
    assign pready    = 1'b1;

    // Line levels {scl_oe, sda_oe} for a given cell position. Data-carrying cells only
    // change SDA at Q0; START and STOP move SDA while SCL is high to form the conditions.
    function automatic logic [1:0] drive(input state_t st, input logic [1:0] q,
                                         input logic [2:0] idx, input logic [7:0] a,
                                         input logic [7:0] d);
        logic [1:0] r;
        r = 2'b00;
        case (st)
            S_START: r = {1'b0, q[1]};
            S_ADDR:  r = {~q[1], ~a[3'd7 - idx]};
            S_DATA:  r = {~q[1], a[0] ? 1'b0 : ~d[3'd7 - idx]};
            S_AACK,
            S_DACK:  r = {~q[1], 1'b0};
            S_STOP:  r = {~q[1], (q != 2'd3)};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Where the FSM goes at the end of the current bit cell.
    always_comb begin
        nxt_state = S_IDLE;
        case (state)
            S_START: nxt_state = S_ADDR;
            S_ADDR:  nxt_state = (bit_cnt == 3'd7) ? S_AACK : S_ADDR;
            S_AACK:  nxt_state = sda_smp ? S_STOP : S_DATA;
            S_DATA:  nxt_state = (bit_cnt == 3'd7) ? S_DACK : S_DATA;
            S_DACK:  nxt_state = S_STOP;
            default: nxt_state = S_IDLE;
        endcase
        nxt_bit = ((state == S_ADDR) || (state == S_DATA)) ? bit_cnt + 3'd1 : 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            addr_snap <= '0;
            tx_snap   <= '0;
            rx_shift  <= '0;
            rx_reg    <= '0;
            sda_smp   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start_go) begin
                state     <= S_START;
                div_cnt   <= '0;
                qtr       <= '0;
                bit_cnt   <= '0;
                addr_snap <= addr_reg;
                tx_snap   <= tx_reg;
                {scl_oe, sda_oe} <= 2'b00;
            end
        end else begin
            if (smp_pt) begin
                sda_smp <= sda_i;
                if ((state == S_DATA) && addr_snap[0])
                    rx_shift <= {rx_shift[6:0], sda_i};
            end
            if (!q_last) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= '0;
                if (qtr != 2'd3) begin
                    qtr <= qtr + 2'd1;
                    {scl_oe, sda_oe} <= drive(state, qtr + 2'd1, bit_cnt, addr_snap, tx_snap);
                end else begin
                    qtr     <= '0;
                    state   <= nxt_state;
                    bit_cnt <= nxt_bit;
                    {scl_oe, sda_oe} <= drive(nxt_state, 2'd0, nxt_bit, addr_snap, tx_snap);
                    // RXDATA only moves once the whole byte is in.
                    if ((state == S_DATA) && (bit_cnt == 3'd7) && addr_snap[0])
                        rx_reg <= rx_shift;
                end
            end
        end
    end

    // Register file and sticky flags; hardware set beats a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
            tx_reg   <= '0;
            nack_flg <= 1'b0;
            done_flg <= 1'b0;
        end else begin
            if (apb_wr && (paddr == 3'd0)) addr_reg <= pwdata;
            if (apb_wr && (paddr == 3'd1)) tx_reg   <= pwdata;
            if (start_go) begin
                nack_flg <= 1'b0;
                done_flg <= 1'b0;
            end else begin
                if (nack_set)
                    nack_flg <= 1'b1;
                else if (apb_wr && (paddr == 3'd3) && pwdata[1])
                    nack_flg <= 1'b0;
                if (done_set)
                    done_flg <= 1'b1;
                else if (apb_wr && (paddr == 3'd3) && pwdata[2])
                    done_flg <= 1'b0;
            end
        end
    end

    always_comb begin
        prdata = 8'h00;
        case (paddr)
            3'd0:    prdata = addr_reg;
            3'd1:    prdata = tx_reg;
            3'd2:    prdata = rx_reg;
            3'd3:    prdata = {5'b0, done_flg, nack_flg, busy};
            default: prdata = 8'h00;
        endcase
    end

endmodule
